// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1 UART receiver with start-glitch rejection,
// framing-error detection and a valid/ack output handshake with overrun flag.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | timing to the middle of the start bit, re-checking it is still low
// DATA   | sampling 8 data bits at their midpoints, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, delivering the byte if the frame is clean
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx_os #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int os_rate   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       par_err
);

  localparam int DIV = clk_freq / (baud_rate * os_rate);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(os_rate);

  localparam logic [TW-1:0] DIV_M1  = TW'((DIV > 0) ? DIV - 1 : 0);
  localparam logic [OW-1:0] OS_M1   = OW'(os_rate - 1);
  localparam logic [OW-1:0] OS_HALF = OW'(os_rate / 2 - 1);

  generate
    if (DIV < 1) begin : g_div_err
      $error("uart_rx_os: clk_freq/(baud_rate*os_rate) must be at least 1");
    end
    if ((os_rate < 8) || (os_rate % 2 != 0)) begin : g_os_err
      $error("uart_rx_os: os_rate must be even and at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [OW-1:0]   os_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            overrun_q;
`ifdef UART_RX_PARITY_EN
  logic            par_ok_q;
  logic            par_err_q;
`endif

  assign tick = (tick_cnt_q == DIV_M1);

  // Free-running oversample tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM with registered outputs; delivery overrides a same-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q    <= 1'b1;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (rx_ack && rx_valid_q) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              state_q  <= S_START;
              os_cnt_q <= '0;
            end
          end
          S_START: begin
            if (os_cnt_q == OS_HALF) begin
              if (!rx_s_q) begin
                state_q   <= S_DATA;
                os_cnt_q  <= '0;
                bit_cnt_q <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
          S_DATA: begin
            if (os_cnt_q == OS_M1) begin
              shift_q   <= {rx_s_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              os_cnt_q  <= '0;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (os_cnt_q == OS_M1) begin
              os_cnt_q <= '0;
              state_q  <= S_STOP;
              if (^{shift_q, rx_s_q}) begin
                par_ok_q  <= 1'b0;
                par_err_q <= 1'b1;
              end else begin
                par_ok_q <= 1'b1;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (os_cnt_q == OS_M1) begin
              os_cnt_q <= '0;
              if (rx_s_q) begin
                state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_ok_q) begin
`else
                begin
`endif
                  if (!rx_valid_q || rx_ack) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                    overrun_q  <= 1'b0;
                  end else begin
                    overrun_q <= 1'b1;
                  end
                end
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
          S_BREAK: begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os at 1.6 MHz / 10 kbaud / 16x (tick every 10 clk,
// 160 clk per bit). Expected stop-sample edges are predicted from the
// free-running tick phase, the 2-flop synchronizer and the mid-bit rules.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int TB_DIV   = CLK_FREQ / (BAUD * OS);
  localparam int BIT_CLK  = TB_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = TB_DIV * (OS / 2) + BIT_CLK * (NB - 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       par_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // observation state
  int   fe_cnt, pe_cnt, vr_cnt, rise_cyc, dchg_cyc, fe_cyc;
  bit   busy_seen;
  logic prev_valid;
  logic [7:0] prev_data;
  int   m_start, exp_done;

  // reference model of the host-side handshake
  logic [7:0] mdata;
  logic       mvalid, movr;

  uart_rx_os #(
    .clk_freq (CLK_FREQ),
    .baud_rate(BAUD),
    .os_rate  (OS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    fe_cnt = 0; pe_cnt = 0; vr_cnt = 0; busy_seen = 0;
    rise_cyc = -1; dchg_cyc = -1; fe_cyc = -1;
    prev_valid = rx_valid; prev_data = rx_data;
  endtask

  task automatic mon();
    if (frame_err === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
    if (par_err === 1'b1) pe_cnt++;
    if (busy === 1'b1) busy_seen = 1;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin vr_cnt++; rise_cyc = cyc; end
    if (rx_data !== prev_data) dchg_cyc = cyc;
    prev_valid = rx_valid;
    prev_data  = rx_data;
  endtask

  task automatic idle(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mon();
      rx = lvl;
      rx_ack = 1'b0;
    end
  endtask

  // Drives one frame bit-by-bit; optionally raises rx_ack only in the
  // cycle of the predicted stop-bit sample; abort_at >= 0 stops early.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit bad_par,
                            input bit ack_done, input int abort_at);
    logic bits [0:10];
    int   n0;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ bad_par;
    bits[10] = stop_b;
`else
    bits[9]  = stop_b;
    bits[10] = 1'b1;
`endif
    clear_mon();
    for (int i = 0; i < NB * BIT_CLK; i++) begin
      @(negedge clk);
      if (abort_at >= 0 && i >= abort_at) break;
      mon();
      if (i == 0) begin
        m_start  = cyc;
        n0       = ((m_start + 3 + TB_DIV - 1) / TB_DIV) * TB_DIV;
        exp_done = n0 + LAT;
      end
      rx     = bits[i / BIT_CLK];
      rx_ack = (ack_done && (cyc == exp_done - 1));
    end
    rx_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    mon();
    rx_ack = 1'b1;
    @(negedge clk);
    mon();
    rx_ack = 1'b0;
    if (mvalid) begin mvalid = 0; movr = 0; end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},  {24'd0, rx_data}, {24'd0, mdata});
    check({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, mvalid});
    check({tag, "_ovr"},   {31'd0, overrun}, {31'd0, movr});
  endtask

  task automatic model_frame(input logic [7:0] d, input bit ack_done);
    if (!mvalid || ack_done) begin mdata = d; mvalid = 1; movr = 0; end
    else movr = 1;
  endtask

  initial begin
    logic [7:0] d;
    bit         a;
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    mdata = 8'h00; mvalid = 0; movr = 0;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, rx_data}, 32'h0);
    check("rst_valid", {31'd0, rx_valid}, 32'h0);
    check("rst_busy",  {31'd0, busy}, 32'h0);
    check("rst_ferr",  {31'd0, frame_err}, 32'h0);
    check("rst_ovr",   {31'd0, overrun}, 32'h0);
    check("rst_perr",  {31'd0, par_err}, 32'h0);
    rst = 1'b0;
    idle(50, 1'b1);

    // 1: clean frame and its latency
    send_frame(8'hA5, 1'b1, 0, 0, -1);
    idle(20, 1'b1);
    model_frame(8'hA5, 0);
    check_model("t1");
    check("t1_ferr_cnt", fe_cnt, 0);
    check("t1_rise_cyc", rise_cyc, exp_done);
    check("t1_window", {31'd0, (rise_cyc - m_start >= LAT - 12) && (rise_cyc - m_start <= LAT + 12)}, 1);
    pulse_ack();
    check_model("t1_ack");

    // 2: start-bit glitch
    clear_mon();
    idle(30, 1'b0);
    idle(300, 1'b1);
    check("t2_busy_seen", {31'd0, busy_seen}, 1);
    check("t2_busy", {31'd0, busy}, 0);
    check("t2_rises", vr_cnt, 0);
    check("t2_ferr_cnt", fe_cnt, 0);
    check_model("t2");

    // 3: framing error, held-low line, then recovery
    send_frame(8'h3C, 1'b0, 0, 0, -1);
    idle(320, 1'b0);
    idle(40, 1'b1);
    check("t3_ferr_cnt", fe_cnt, 1);
    check("t3_ferr_cyc", fe_cyc, exp_done);
    check("t3_rises", vr_cnt, 0);
    check("t3_busy", {31'd0, busy}, 0);
    check_model("t3_err");
    send_frame(8'h81, 1'b1, 0, 0, -1);
    idle(20, 1'b1);
    model_frame(8'h81, 0);
    check_model("t3_81");
    check("t3_ferr_cnt2", fe_cnt, 0);

    // 4: overrun, ack clear, ack coinciding with completion
    pulse_ack();
    send_frame(8'h11, 1'b1, 0, 0, -1); idle(20, 1'b1); model_frame(8'h11, 0);
    send_frame(8'h22, 1'b1, 0, 0, -1); idle(20, 1'b1); model_frame(8'h22, 0);
    check_model("t4_ovr");
    pulse_ack();
    check_model("t4_ack");
    send_frame(8'h44, 1'b1, 0, 0, -1); idle(20, 1'b1); model_frame(8'h44, 0);
    check_model("t4_44");
    send_frame(8'h33, 1'b1, 0, 1, -1); idle(20, 1'b1); model_frame(8'h33, 1);
    check_model("t4_33");
    check("t4_dchg_cyc", dchg_cyc, exp_done);
    check("t4_no_rise", vr_cnt, 0);

    // 5: reset mid-frame
    send_frame(8'h5A, 1'b1, 0, 0, 5 * BIT_CLK);
    rst = 1'b1; rx = 1'b1;
    mdata = 8'h00; mvalid = 0; movr = 0;
    repeat (3) @(negedge clk);
    check("t5_rst_data",  {24'd0, rx_data}, 32'h0);
    check("t5_rst_valid", {31'd0, rx_valid}, 32'h0);
    check("t5_rst_busy",  {31'd0, busy}, 32'h0);
    check("t5_rst_ovr",   {31'd0, overrun}, 32'h0);
    check("t5_rst_ferr",  {31'd0, frame_err}, 32'h0);
    rst = 1'b0;
    clear_mon();
    idle(50, 1'b1);
    check("t5_no_partial", vr_cnt, 0);
    send_frame(8'h5A, 1'b1, 0, 0, -1);
    idle(200, 1'b1);
    model_frame(8'h5A, 0);
    check_model("t5");
    check("t5_one_delivery", vr_cnt, 1);

`ifdef UART_RX_PARITY_EN
    // 6: parity
    pulse_ack();
    send_frame(8'h07, 1'b1, 1, 0, -1);
    idle(20, 1'b1);
    check("t6_perr_cnt", pe_cnt, 1);
    check("t6_rises", vr_cnt, 0);
    check_model("t6_bad");
    send_frame(8'h07, 1'b1, 0, 0, -1);
    idle(20, 1'b1);
    model_frame(8'h07, 0);
    check("t6_perr_cnt2", pe_cnt, 0);
    check_model("t6_good");
`endif

    // randomized frames and acks against the handshake model
    pulse_ack();
    for (int r = 0; r < 8; r++) begin
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      send_frame(d, 1'b1, 0, a, -1);
      idle(20, 1'b1);
      model_frame(d, a);
      check_model("rnd");
      check("rnd_ferr_cnt", fe_cnt, 0);
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack();
        check_model("rnd_ack");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
